// File: rtl/dtmr_pkg.sv
// Shared definitions for the dynamic-TMR sequencer: FSM state encoding and
// a small popcount helper for the 3-bit voter fault vector.
package dtmr_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_TMR    = 2'd1,
    ST_RESYNC = 2'd2,
    ST_FATAL  = 2'd3
  } dtmr_state_e;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/dtmr_fault_cnt.sv
// Per-copy consecutive-fault run counter. Counts only while enabled and the
// copy's fault flag is set, saturates at THRESH, and flags the cycle on which
// the run reaches THRESH so the sequencer can react on that same edge.
module dtmr_fault_cnt #(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic fault_bit,
  output logic hit
);

  localparam int W = $clog2(THRESH + 1);
  localparam logic [W-1:0] THR = W'(THRESH);
  localparam logic [W-1:0] THR_M1 = W'(THRESH - 1);

  logic [W-1:0] cnt;

  assign hit = en & fault_bit & (cnt >= THR_M1);

  // Run length of back-to-back faulty cycles; any clean or disabled cycle clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || !fault_bit) begin
      cnt <= '0;
    end else if (cnt != THR) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dtmr_ctrl.sv
// Dynamic-TMR sequencer: runs single-copy in NORMAL, votes in TMR, reloads a
// persistently faulty copy in RESYNC and latches FATAL on multi-copy faults.
// Optional statistics counters are enabled by defining DTMR_STATS_EN.
module dtmr_ctrl
  import dtmr_pkg::*;
#(
  parameter int FAULT_THRESH  = 4,
  parameter int RESYNC_CYCLES = 8,
  parameter int QUIET_CYCLES  = 16,
  parameter int CHECK_PERIOD  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_req,
  input  logic [2:0] fault,
  input  logic       clr_fatal,
  output logic       tmr_state,
  output logic [2:0] resync,
  output logic       fatal,
  output logic [1:0] fsm_state
`ifdef DTMR_STATS_EN
  ,
  output logic [7:0] fault_cnt1,
  output logic [7:0] fault_cnt2,
  output logic [7:0] fault_cnt3,
  output logic [7:0] resync_cnt
`endif
);

  localparam int PW = $clog2(CHECK_PERIOD + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int RW = $clog2(RESYNC_CYCLES + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(CHECK_PERIOD - 1);
  localparam logic [QW-1:0] QUIET_LAST  = QW'(QUIET_CYCLES - 1);
  localparam logic [RW-1:0] RS_LAST     = RW'(RESYNC_CYCLES - 1);

  dtmr_state_e   state;
  logic [PW-1:0] period_cnt;
  logic [QW-1:0] quiet_cnt;
  logic [RW-1:0] rs_cnt;
  logic [2:0]    target;
  logic [2:0]    hit;
  logic [2:0]    hit_1h;
  logic          multi_fault;
  logic          run_en;

  assign run_en      = (state == ST_TMR);
  assign multi_fault = (popcount3(fault) >= 2'd2);
  assign fsm_state   = state;

  for (genvar i = 0; i < 3; i++) begin : g_run
    dtmr_fault_cnt #(
      .THRESH(FAULT_THRESH)
    ) u_run (
      .clk      (clk),
      .rst      (rst),
      .en       (run_en),
      .fault_bit(fault[i]),
      .hit      (hit[i])
    );
  end

  // Reduce threshold hits to a single one-hot resync target (lowest copy wins).
  always_comb begin
    hit_1h = 3'b000;
    if (hit[0])      hit_1h = 3'b001;
    else if (hit[1]) hit_1h = 3'b010;
    else if (hit[2]) hit_1h = 3'b100;
  end

  // Main sequencer: state, phase counters and all registered outputs move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_NORMAL;
      period_cnt <= '0;
      quiet_cnt  <= '0;
      rs_cnt     <= '0;
      target     <= 3'b000;
      tmr_state  <= 1'b0;
      resync     <= 3'b000;
      fatal      <= 1'b0;
    end else begin
      case (state)
        ST_NORMAL: begin
          if (mode_req || period_cnt == PERIOD_LAST) begin
            state      <= ST_TMR;
            tmr_state  <= 1'b1;
            period_cnt <= '0;
            quiet_cnt  <= '0;
          end else begin
            period_cnt <= period_cnt + 1'b1;
          end
        end
        ST_TMR: begin
          if (multi_fault) begin
            state <= ST_FATAL;
            fatal <= 1'b1;
          end else if (|hit) begin
            state  <= ST_RESYNC;
            target <= hit_1h;
            resync <= hit_1h;
            rs_cnt <= '0;
          end else if (|fault) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt == QUIET_LAST) begin
            if (!mode_req) begin
              state      <= ST_NORMAL;
              tmr_state  <= 1'b0;
              period_cnt <= '0;
            end
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        ST_RESYNC: begin
          if (|(fault & ~target)) begin
            state  <= ST_FATAL;
            fatal  <= 1'b1;
            resync <= 3'b000;
          end else if (rs_cnt == RS_LAST) begin
            state     <= ST_TMR;
            resync    <= 3'b000;
            quiet_cnt <= '0;
          end else begin
            rs_cnt <= rs_cnt + 1'b1;
          end
        end
        ST_FATAL: begin
          if (clr_fatal) begin
            state     <= ST_TMR;
            fatal     <= 1'b0;
            quiet_cnt <= '0;
          end
        end
        default: begin
          state     <= ST_NORMAL;
          tmr_state <= 1'b0;
          resync    <= 3'b000;
          fatal     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DTMR_STATS_EN
  logic [7:0] fcnt [3];
  logic [7:0] rcnt;

  assign fault_cnt1 = fcnt[0];
  assign fault_cnt2 = fcnt[1];
  assign fault_cnt3 = fcnt[2];
  assign resync_cnt = rcnt;

  // Lifetime statistics: faulty voting cycles per copy and resync entries, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) fcnt[i] <= 8'd0;
      rcnt <= 8'd0;
    end else begin
      if (state == ST_TMR || state == ST_RESYNC) begin
        for (int i = 0; i < 3; i++) begin
          if (fault[i] && fcnt[i] != 8'hFF) fcnt[i] <= fcnt[i] + 8'd1;
        end
      end
      if (state == ST_TMR && !multi_fault && (|hit) && rcnt != 8'hFF) begin
        rcnt <= rcnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dtmr_ctrl.sv
// Scoreboard bench for dtmr_ctrl: stimulus pushes expected outputs tagged with
// a cycle number; a monitor pops and compares them as the DUT reaches that cycle.
// Statistics ports are connected and checked when DTMR_STATS_EN is defined.
module tb_dtmr_ctrl;

  localparam logic [1:0] S_NORMAL = 2'd0;
  localparam logic [1:0] S_TMR    = 2'd1;
  localparam logic [1:0] S_RESYNC = 2'd2;
  localparam logic [1:0] S_FATAL  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_req = 1'b0;
  logic [2:0] fault = 3'b000;
  logic       clr_fatal = 1'b0;
  logic       tmr_state;
  logic [2:0] resync;
  logic       fatal;
  logic [1:0] fsm_state;
`ifdef DTMR_STATS_EN
  logic [7:0] fault_cnt1, fault_cnt2, fault_cnt3, resync_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic       tmr;
    logic [2:0] rs;
    logic       fat;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];

  dtmr_ctrl #(
    .FAULT_THRESH (4),
    .RESYNC_CYCLES(8),
    .QUIET_CYCLES (16),
    .CHECK_PERIOD (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_req (mode_req),
    .fault    (fault),
    .clr_fatal(clr_fatal),
    .tmr_state(tmr_state),
    .resync   (resync),
    .fatal    (fatal),
    .fsm_state(fsm_state)
`ifdef DTMR_STATS_EN
    ,
    .fault_cnt1(fault_cnt1),
    .fault_cnt2(fault_cnt2),
    .fault_cnt3(fault_cnt3),
    .resync_cnt(resync_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic et, input logic [2:0] ers,
                             input logic ef, input logic [1:0] est);
    total++;
    if ({tmr_state, resync, fatal, fsm_state} !== {et, ers, ef, est}) begin
      bad++;
      $display("[TB] FAIL %s @cyc %0d: got tmr=%0b resync=%03b fatal=%0b fsm=%0d, want tmr=%0b resync=%03b fatal=%0b fsm=%0d",
               name, cyc, tmr_state, resync, fatal, fsm_state, et, ers, ef, est);
    end
  endtask

  task automatic expectOutput(input string name, input logic et, input logic [2:0] ers,
                              input logic ef, input logic [1:0] est);
    exp_t e;
    e.cyc = cyc; e.name = name; e.tmr = et; e.rs = ers; e.fat = ef; e.st = est;
    sbq.push_back(e);
  endtask

  // Drive inputs and let n rising edges sample them; returns on a falling edge.
  task automatic applyStimulus(input logic m, input logic [2:0] f, input logic c, input int n);
    mode_req = m; fault = f; clr_fatal = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic enterTmr(input string name);
    applyStimulus(1'b1, 3'b000, 1'b0, 1);
    expectOutput(name, 1'b1, 3'b000, 1'b0, S_TMR);
  endtask

  // Monitor: compare every expectation whose cycle has been reached.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        checkOutput(e.name, e.tmr, e.rs, e.fat, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit dropped;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expectOutput("reset", 1'b0, 3'b000, 1'b0, S_NORMAL);

    // 1: periodic self-check entry and quiet return
    applyStimulus(1'b0, 3'b000, 1'b0, 255);
    expectOutput("t1 idle255", 1'b0, 3'b000, 1'b0, S_NORMAL);
    applyStimulus(1'b0, 3'b000, 1'b0, 1);
    expectOutput("t1 check256", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b000, 1'b0, 15);
    expectOutput("t1 quiet15", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b000, 1'b0, 1);
    expectOutput("t1 quiet16", 1'b0, 3'b000, 1'b0, S_NORMAL);

    // 2: external request holds voting
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 3'b000, 1'b0, 1);
      expectOutput("t2 hold", 1'b1, 3'b000, 1'b0, S_TMR);
    end
    dropped = 1'b0;
    for (int i = 0; i < 17 && !dropped; i++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 1);
      if (tmr_state === 1'b0) dropped = 1'b1;
    end
    checkOutput("t2 release", 1'b0, 3'b000, 1'b0, S_NORMAL);

    // 3: persistent fault on copy 2 triggers resync; short run does not
    enterTmr("t3 enter");
    applyStimulus(1'b0, 3'b010, 1'b0, 3);
    expectOutput("t3 run3", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b010, 1'b0, 1);
    expectOutput("t3 run4", 1'b1, 3'b010, 1'b0, S_RESYNC);
    applyStimulus(1'b0, 3'b010, 1'b0, 7);
    expectOutput("t3 rs8th", 1'b1, 3'b010, 1'b0, S_RESYNC);
    applyStimulus(1'b0, 3'b010, 1'b0, 1);
    expectOutput("t3 rs done", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b001, 1'b0, 3);
    expectOutput("t3 run3 c1", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b000, 1'b0, 1);
    expectOutput("t3 no rs", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b000, 1'b0, 14);
    expectOutput("t3 quiet15", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b000, 1'b0, 1);
    expectOutput("t3 quiet16", 1'b0, 3'b000, 1'b0, S_NORMAL);

    // 4: multi-copy fault is fatal and sticky until cleared
    enterTmr("t4 enter");
    applyStimulus(1'b0, 3'b101, 1'b0, 1);
    expectOutput("t4 fatal", 1'b1, 3'b000, 1'b1, S_FATAL);
    applyStimulus(1'b1, 3'b000, 1'b0, 3);
    expectOutput("t4 sticky", 1'b1, 3'b000, 1'b1, S_FATAL);
    applyStimulus(1'b0, 3'b000, 1'b1, 1);
    expectOutput("t4 clear", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b000, 1'b0, 16);
    expectOutput("t4 normal", 1'b0, 3'b000, 1'b0, S_NORMAL);

    // 5: foreign fault during resync escalates to fatal
    enterTmr("t5 enter");
    applyStimulus(1'b0, 3'b010, 1'b0, 4);
    expectOutput("t5 rs", 1'b1, 3'b010, 1'b0, S_RESYNC);
    applyStimulus(1'b0, 3'b001, 1'b0, 1);
    expectOutput("t5 fatal", 1'b1, 3'b000, 1'b1, S_FATAL);
    applyStimulus(1'b0, 3'b000, 1'b1, 1);
    expectOutput("t5 clear", 1'b1, 3'b000, 1'b0, S_TMR);
    applyStimulus(1'b0, 3'b000, 1'b0, 16);
    expectOutput("t5 normal", 1'b0, 3'b000, 1'b0, S_NORMAL);

    // 6: asynchronous reset in the middle of a resync
    enterTmr("t6 enter");
    applyStimulus(1'b0, 3'b100, 1'b0, 4);
    expectOutput("t6 rs", 1'b1, 3'b100, 1'b0, S_RESYNC);
    applyStimulus(1'b0, 3'b000, 1'b0, 2);
    expectOutput("t6 rs hold", 1'b1, 3'b100, 1'b0, S_RESYNC);
    #2;
`ifdef DTMR_STATS_EN
    total++;
    if (resync_cnt !== 8'd3) begin
      bad++;
      $display("[TB] FAIL stats resync_cnt: got %0d want 3", resync_cnt);
    end
`endif
    rst = 1'b1;
    #1;
    checkOutput("t6 async rst", 1'b0, 3'b000, 1'b0, S_NORMAL);
`ifdef DTMR_STATS_EN
    total++;
    if ({fault_cnt1, fault_cnt2, fault_cnt3, resync_cnt} !== 32'd0) begin
      bad++;
      $display("[TB] FAIL stats rst: got %0d %0d %0d %0d want 0", fault_cnt1, fault_cnt2,
               fault_cnt3, resync_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 3'b000, 1'b0, 3);
    expectOutput("t6 no resume", 1'b0, 3'b000, 1'b0, S_NORMAL);

    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
